// File: rtl/replicator.sv
// Registered four-input truth-table evaluator. Two run-time writable 16-entry
// tables are indexed by {a,b,c,d}, and the results are registered onto out1/out2.
module replicator #(
    parameter logic [15:0] OUT1_TT = 16'h6996,
    parameter logic [15:0] OUT2_TT = 16'hF666
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a,
    input  logic        b,
    input  logic        c,
    input  logic        d,
    input  logic        tt_load,
    input  logic        tt_sel,
    input  logic [15:0] tt_data,
    output logic        out1,
    output logic        out2,
    output logic        out_valid
);
    localparam int NUM_OUT = 2;

    logic [3:0]                     idx;
    logic [NUM_OUT-1:0][15:0]       tt_q, tt_d;
    logic [NUM_OUT-1:0]             out_q, out_d;
    logic                           out_valid_q, out_valid_d;

    assign idx = {a, b, c, d};

    // Evaluation reads the current tables, so a load only shows up one edge later.
    always_comb begin
        tt_d        = tt_q;
        out_valid_d = 1'b1;
        if (tt_load) begin
            tt_d[tt_sel] = tt_data;
        end
        for (int i = 0; i < NUM_OUT; i++) begin
            out_d[i] = tt_q[i][idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt_q        <= {OUT2_TT, OUT1_TT};
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            tt_q        <= tt_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out1      = out_q[0];
    assign out2      = out_q[1];
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_replicator.sv
// Directed scoreboard bench for replicator: the driver queues hand-computed
// {out_valid,out1,out2} per cycle, and the monitor pops and compares after each edge.
module tb_replicator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic        tt_load = 1'b0;
    logic        tt_sel = 1'b0;
    logic [15:0] tt_data = '0;
    logic        out1, out2, out_valid;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [2:0]  sb[$];
    logic [2:0]  held;
    logic        have_held = 1'b0;

    replicator dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d),
        .tt_load(tt_load), .tt_sel(tt_sel), .tt_data(tt_data),
        .out1(out1), .out2(out2), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    // Driver: apply one vector away from the active edge and queue its expected result.
    task automatic step(input logic rn, input logic [3:0] in, input logic ld,
                        input logic sel, input logic [15:0] dat,
                        input logic ev, input logic e1, input logic e2);
        @(negedge clk);
        rst_n = rn;
        {a, b, c, d} = in;
        tt_load = ld;
        tt_sel = sel;
        tt_data = dat;
        sb.push_back({ev, e1, e2});
    endtask

    always @(posedge clk) begin
        logic [2:0] exp_v;
        #1;
        if (sb.size() > 0) begin
            exp_v = sb.pop_front();
            n_chk++;
            if ({out_valid, out1, out2} !== exp_v)
                $display("FAIL outputs t=%0t: got valid/out1/out2=%b required %b",
                         $time, {out_valid, out1, out2}, exp_v);
            if ({out_valid, out1, out2} !== exp_v) n_fail++;
        end
        held = {out_valid, out1, out2};
        have_held = 1'b1;
    end

    // Outputs must not move between edges.
    always @(negedge clk) begin
        if (have_held) begin
            n_chk++;
            if ({out_valid, out1, out2} !== held) begin
                n_fail++;
                $display("FAIL stable t=%0t: got %b required %b", $time,
                         {out_valid, out1, out2}, held);
            end
        end
    end

    initial begin
        logic e1_def[16] = '{0,1,1,0,1,0,0,1,1,0,0,1,0,1,1,0};
        logic e2_def[16] = '{0,1,1,0,0,1,1,0,0,1,1,0,1,1,1,1};
        logic [3:0] r;

        // Reset held two edges with all inputs high.
        step(0, 4'b1111, 0, 0, 16'h0, 0, 0, 0);
        step(0, 4'b1111, 0, 0, 16'h0, 0, 0, 0);
        step(1, 4'b1111, 0, 0, 16'h0, 1, 0, 1);

        // Default exhaustive sweep.
        for (int i = 0; i < 16; i++)
            step(1, 4'(i), 0, 0, 16'h0, 1, e1_def[i], e2_def[i]);

        // Load out2 table = 8000: old value on load edge, new value afterwards.
        step(1, 4'b1111, 1, 1, 16'h8000, 1, 0, 1);
        step(1, 4'b1111, 0, 1, 16'h0000, 1, 0, 1);
        step(1, 4'b1110, 0, 0, 16'hFFFF, 1, 1, 0);

        // Load out1 table = 0001; out2 keeps 8000.
        step(1, 4'b0000, 1, 0, 16'h0001, 1, 0, 0);
        for (int i = 0; i < 16; i++)
            step(1, 4'(i), 0, 1, 16'hAAAA, 1, (i == 0), (i == 15));

        // Reset with a simultaneous load: load ignored, tables revert.
        step(0, 4'b0000, 1, 0, 16'hFFFF, 0, 0, 0);
        for (int i = 0; i < 16; i++)
            step(1, 4'(i), 0, 0, 16'h0, 1, e1_def[i], e2_def[i]);

        // Back-to-back loads to tt2 (last wins), then tt1 on the next cycle.
        step(1, 4'b0000, 1, 1, 16'h0000, 1, 0, 0);
        step(1, 4'b0000, 1, 1, 16'hFFFF, 1, 0, 0);
        step(1, 4'b0101, 1, 0, 16'hFFFF, 1, 0, 1);
        step(1, 4'b0101, 0, 0, 16'h0000, 1, 1, 1);
        step(1, 4'b0000, 0, 0, 16'h0000, 1, 1, 1);

        // Revert to defaults, then random inputs checked against the Boolean forms.
        step(0, 4'b0000, 0, 0, 16'h0, 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            r = 4'($urandom_range(0, 15));
            step(1, r, 0, 0, 16'h0, 1, ^r, (r[3] & r[2]) | (r[1] ^ r[0]));
        end

        repeat (3) @(posedge clk);
        #2;
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
